// File: rtl/cpu_bus_responder_pkg.sv
// ============================================================================
// Module : cpu_bus_responder_pkg
// Brief  : Shared encodings and defaults for the CPU bus responder slice.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_bus_responder_pkg;

    localparam logic [0:0] c_RSP_IDLE = 1'b0;
    localparam logic [0:0] c_RSP_WAIT = 1'b1;

    localparam logic [0:0] c_PH_H = 1'b1;
    localparam logic [0:0] c_PH_L = 1'b0;

    // 6502 NOP opcode, harmless if fetched after an aborted read
    localparam logic [7:0] c_FILL_BYTE_DEFAULT = 8'hEA;

endpackage

`default_nettype wire

// File: rtl/cpu_bus_responder_if.sv
// ============================================================================
// Module : cpu_bus_responder_if
// Brief  : CPU pin stream, memory req/ack port and status of the responder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_bus_responder_if;
    logic        phase_sync;
    logic [7:0]  cpu_addr_pins;
    logic [7:0]  cpu_data_pins;
    logic [7:0]  cpu_data_oe;
    logic [7:0]  cpu_rdata;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        overrun;
    logic        timeout_err;
    logic [15:0] bus_cycles;

    modport master (
        output phase_sync, cpu_addr_pins, cpu_data_pins, cpu_data_oe,
        output mem_rdata, mem_ack,
        input  cpu_rdata, mem_req, mem_addr, mem_we, mem_wdata,
        input  overrun, timeout_err, bus_cycles
    );

    modport slave (
        input  phase_sync, cpu_addr_pins, cpu_data_pins, cpu_data_oe,
        input  mem_rdata, mem_ack,
        output cpu_rdata, mem_req, mem_addr, mem_we, mem_wdata,
        output overrun, timeout_err, bus_cycles
    );
endinterface

`default_nettype wire

// File: rtl/cpu_bus_responder_phase_tracker.sv
// ============================================================================
// Module : cpu_bus_phase_tracker
// Brief  : H/L phase toggle with resync, plus phase-H address/data capture.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_bus_phase_tracker
    import cpu_bus_responder_pkg::*;
#(
    parameter bit START_PHASE_H = 1'b1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_phase_sync,
    input  wire logic [7:0] i_addr_pins,
    input  wire logic [7:0] i_data_pins,
    output logic            o_phase_h,
    output logic [7:0]      o_addr_hi,
    output logic [7:0]      o_wdata_cap
);

    localparam logic [0:0] c_START_PHASE = START_PHASE_H ? c_PH_H : c_PH_L;

    logic [0:0] r_phase;
    logic [7:0] r_addr_hi;
    logic [7:0] r_wdata_cap;
    logic       w_phase_h;

    // phase_sync overrides the toggle so the following cycle is always L
    assign w_phase_h = i_phase_sync | (r_phase == c_PH_H);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase     <= c_START_PHASE;
            r_addr_hi   <= 8'h00;
            r_wdata_cap <= 8'h00;
        end else begin
            r_phase <= w_phase_h ? c_PH_L : c_PH_H;
            if (w_phase_h) begin
                r_addr_hi   <= i_addr_pins;
                r_wdata_cap <= i_data_pins;
            end
        end
    end

    assign o_phase_h   = w_phase_h;
    assign o_addr_hi   = r_addr_hi;
    assign o_wdata_cap = r_wdata_cap;

endmodule

`default_nettype wire

// File: rtl/cpu_bus_responder.sv
// ============================================================================
// Module : cpu_bus_responder
// Brief  : Rebuilds 6502 two-phase pin cycles into req/ack memory requests.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_bus_responder
    import cpu_bus_responder_pkg::*;
#(
    parameter int         TIMEOUT       = 8,
    parameter logic [7:0] FILL_BYTE     = c_FILL_BYTE_DEFAULT,
    parameter bit         START_PHASE_H = 1'b1
) (
    input wire logic            clk,
    input wire logic            rst,
    cpu_bus_responder_if.slave  bus
);

    localparam int c_CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic [15:0]        r_mem_addr;
    logic               r_mem_we;
    logic [7:0]         r_mem_wdata;
    logic [7:0]         r_cpu_rdata;
    logic               r_overrun;
    logic               r_timeout_err;
    logic [15:0]        r_bus_cycles;

    logic       w_phase_h;
    logic       w_phase_l;
    logic [7:0] w_addr_hi;
    logic [7:0] w_wdata_cap;
    logic       w_is_write;
    logic       w_issue;
    logic       w_ack_done;
    logic       w_tmo_done;
    logic       w_mem_req;

    cpu_bus_phase_tracker #(
        .START_PHASE_H (START_PHASE_H)
    ) u_phase (
        .clk          (clk),
        .rst          (rst),
        .i_phase_sync (bus.phase_sync),
        .i_addr_pins  (bus.cpu_addr_pins),
        .i_data_pins  (bus.cpu_data_pins),
        .o_phase_h    (w_phase_h),
        .o_addr_hi    (w_addr_hi),
        .o_wdata_cap  (w_wdata_cap)
    );

    assign w_phase_l = ~w_phase_h;
    // rw=0 without full output enable is not a genuine write; serve it as a read
    assign w_is_write = ~bus.cpu_data_pins[0] & (bus.cpu_data_oe == 8'hFF);
    assign w_issue    = (r_state == c_RSP_IDLE) & w_phase_l;
    assign w_ack_done = (r_state == c_RSP_WAIT) & bus.mem_ack;
    assign w_tmo_done = (r_state == c_RSP_WAIT) & ~bus.mem_ack & (r_wait_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_RSP_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_RSP_IDLE: if (w_issue) w_state_nxt = c_RSP_WAIT;
            c_RSP_WAIT: if (w_ack_done || w_tmo_done) w_state_nxt = c_RSP_IDLE;
            default:    w_state_nxt = c_RSP_IDLE;
        endcase
    end

    always_comb begin
        w_mem_req = (r_state == c_RSP_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt    <= '0;
            r_mem_addr    <= 16'h0000;
            r_mem_we      <= 1'b0;
            r_mem_wdata   <= 8'h00;
            r_cpu_rdata   <= 8'h00;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_bus_cycles  <= 16'h0000;
        end else begin
            if (w_issue) begin
                r_mem_addr  <= {w_addr_hi, bus.cpu_addr_pins};
                r_mem_we    <= w_is_write;
                r_mem_wdata <= w_wdata_cap;
                r_wait_cnt  <= '0;
            end else if (r_state == c_RSP_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_ack_done && !r_mem_we) r_cpu_rdata <= bus.mem_rdata;
            if (w_tmo_done) begin
                if (!r_mem_we) r_cpu_rdata <= FILL_BYTE;
                r_timeout_err <= 1'b1;
            end
            if (w_ack_done || w_tmo_done) r_bus_cycles <= r_bus_cycles + 16'd1;
            // a new bus cycle landing on a busy responder is dropped, not queued
            if ((r_state == c_RSP_WAIT) && w_phase_l) r_overrun <= 1'b1;
        end
    end

    assign bus.mem_req     = w_mem_req;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.cpu_rdata   = r_cpu_rdata;
    assign bus.overrun     = r_overrun;
    assign bus.timeout_err = r_timeout_err;
    assign bus.bus_cycles  = r_bus_cycles;

endmodule

`default_nettype wire
